// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED matrix command path: sequencer states,
// UART command byte values and a small state classification helper.
package led_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_ROW,
        GET_COL,
        GET_R,
        GET_G,
        GET_B,
        GET_LEVEL,
        WRITE
    } seq_state_t;

    localparam logic [7:0] CMD_RED_ON    = 8'h52; // "R"
    localparam logic [7:0] CMD_RED_OFF   = 8'h72; // "r"
    localparam logic [7:0] CMD_GREEN_ON  = 8'h47; // "G"
    localparam logic [7:0] CMD_GREEN_OFF = 8'h67; // "g"
    localparam logic [7:0] CMD_BLUE_ON   = 8'h42; // "B"
    localparam logic [7:0] CMD_BLUE_OFF  = 8'h62; // "b"
    localparam logic [7:0] CMD_LEVEL     = 8'h4C; // "L"
    localparam logic [7:0] CMD_PIXEL     = 8'h50; // "P"

    // The payload-collecting states are the only ones that run the inter-byte timeout.
    function automatic logic is_get_state(input seq_state_t s);
        return (s != IDLE) && (s != WRITE);
    endfunction

endpackage

// File: rtl/cmd_sequencer_if.sv
// Pixel write channel from the command sequencer to the frame buffer
// (valid/ready handshake carrying row, column and {R,G,B}).
interface cmd_sequencer_if #(
    parameter int ROW_WIDTH = 4,
    parameter int COL_WIDTH = 5
);
    logic                 pix_wr_valid;
    logic                 pix_wr_ready;
    logic [ROW_WIDTH-1:0] pix_wr_row;
    logic [COL_WIDTH-1:0] pix_wr_col;
    logic [23:0]          pix_wr_rgb;

    modport master (
        output pix_wr_valid,
        output pix_wr_row,
        output pix_wr_col,
        output pix_wr_rgb,
        input  pix_wr_ready
    );

    modport slave (
        input  pix_wr_valid,
        input  pix_wr_row,
        input  pix_wr_col,
        input  pix_wr_rgb,
        output pix_wr_ready
    );
endinterface

// File: rtl/byte_timeout.sv
// Inter-byte idle counter: flags expiry once TIMEOUT_CYCLES-1 cycles have
// elapsed with enable high and no clear.
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 5_320_000,
    parameter int TIMEOUT_WIDTH  = 23
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [TIMEOUT_WIDTH-1:0] LAST_COUNT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] ONE        = TIMEOUT_WIDTH'(1);

    logic [TIMEOUT_WIDTH-1:0] count;

    assign expired = enable && (count == LAST_COUNT);

    // Saturates at the expiry value so a stalled owner never sees a wrap.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + ONE;
        end
    end
endmodule

// File: rtl/cmd_sequencer.sv
// UART byte command decoder for the LED matrix: channel enables, brightness
// and single-pixel writes with an inter-byte timeout.
module cmd_sequencer
    import led_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5_320_000,
    parameter int TIMEOUT_WIDTH  = 23,
    parameter int ROWS           = 16,
    parameter int COLS           = 32
) (
    input  logic                   clk_in,
    input  logic                   reset_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [2:0]             rgb_enable,
    output logic [7:0]             brightness,
    cmd_sequencer_if.master        pix,
    output logic                   busy,
    output logic                   err_pulse
);
    localparam int ROW_WIDTH = $clog2(ROWS);
    localparam int COL_WIDTH = $clog2(COLS);

    seq_state_t state, next_state;
    logic       err_next;
    logic       in_get;
    logic       expired;
    logic       in_range;
    logic [1:0] rst_sync;
    logic       rst_n;
    logic [7:0] row_q, col_q, red_q, green_q;

    // Reset asserts immediately but releases two clock edges later, aligned to clk_in.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    assign in_get   = is_get_state(state);
    assign in_range = (32'(row_q) < ROWS) && (32'(col_q) < COLS);

    byte_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_timeout (
        .clk_in  (clk_in),
        .reset_n (rst_n),
        .clear   (rx_valid || !in_get),
        .enable  (in_get),
        .expired (expired)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A byte arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        next_state = state;
        err_next   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_LEVEL) begin
                        next_state = GET_LEVEL;
                    end else if (rx_data == CMD_PIXEL) begin
                        next_state = GET_ROW;
                    end
                end
            end
            GET_LEVEL: if (rx_valid) next_state = IDLE;
            GET_ROW:   if (rx_valid) next_state = GET_COL;
            GET_COL:   if (rx_valid) next_state = GET_R;
            GET_R:     if (rx_valid) next_state = GET_G;
            GET_G:     if (rx_valid) next_state = GET_B;
            GET_B: begin
                if (rx_valid) begin
                    if (in_range) begin
                        next_state = WRITE;
                    end else begin
                        next_state = IDLE;
                        err_next   = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (rx_valid) err_next = 1'b1;
                if (pix.pix_wr_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (in_get && !rx_valid && expired) begin
            next_state = IDLE;
            err_next   = 1'b1;
        end
    end

    // Range checks use the full received bytes; only the accepted write is truncated.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rgb_enable       <= 3'b111;
            brightness       <= 8'hFF;
            busy             <= 1'b0;
            err_pulse        <= 1'b0;
            row_q            <= '0;
            col_q            <= '0;
            red_q            <= '0;
            green_q          <= '0;
            pix.pix_wr_valid <= 1'b0;
            pix.pix_wr_row   <= '0;
            pix.pix_wr_col   <= '0;
            pix.pix_wr_rgb   <= '0;
        end else begin
            busy      <= (next_state != IDLE);
            err_pulse <= err_next;
            if (rx_valid) begin
                unique case (state)
                    IDLE: begin
                        case (rx_data)
                            CMD_RED_ON:    rgb_enable[0] <= 1'b1;
                            CMD_RED_OFF:   rgb_enable[0] <= 1'b0;
                            CMD_GREEN_ON:  rgb_enable[1] <= 1'b1;
                            CMD_GREEN_OFF: rgb_enable[1] <= 1'b0;
                            CMD_BLUE_ON:   rgb_enable[2] <= 1'b1;
                            CMD_BLUE_OFF:  rgb_enable[2] <= 1'b0;
                            default: ;
                        endcase
                    end
                    GET_LEVEL: brightness <= rx_data;
                    GET_ROW:   row_q      <= rx_data;
                    GET_COL:   col_q      <= rx_data;
                    GET_R:     red_q      <= rx_data;
                    GET_G:     green_q    <= rx_data;
                    GET_B: begin
                        if (in_range) begin
                            pix.pix_wr_valid <= 1'b1;
                            pix.pix_wr_row   <= row_q[ROW_WIDTH-1:0];
                            pix.pix_wr_col   <= col_q[COL_WIDTH-1:0];
                            pix.pix_wr_rgb   <= {red_q, green_q, rx_data};
                        end
                    end
                    default: ;
                endcase
            end
            if (state == WRITE && pix.pix_wr_ready) begin
                pix.pix_wr_valid <= 1'b0;
            end
        end
    end
endmodule
